// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select width and per-channel state type for demux1to4_reg
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic {CH_EMPTY = 1'b0, CH_FULL = 1'b1} ch_state_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register (clk, rst, load, din -> dout, valid/ready); load wins over drain, dout kept after drain
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  input  logic         ready
);
  ch_state_t state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CH_EMPTY;
      dout  <= '0;
    end else begin
      if (load) dout <= din;
      state <= load ? CH_FULL : (ready ? CH_EMPTY : state);
    end
  end
  assign valid = state == CH_FULL;
endmodule

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: registered 1-to-4 demux (in_data/in_valid/in_ready/sel -> 4x out_data/out_valid/out_ready, xfer_cnt); DEMUX_RR_EN replaces sel with a round-robin pointer
module demux1to4_reg
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_CH*W-1:0] out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [CNT_W-1:0]    xfer_cnt
);
  logic [SEL_W-1:0] d;
  logic accept;
`ifdef DEMUX_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic unused_sel;
  assign unused_sel = ^sel;
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (accept) rr_ptr <= rr_ptr + 1'b1;
  end
  assign d = rr_ptr;
`else
  assign d = sel;
`endif
  assign in_ready = !out_valid[d] | out_ready[d];
  assign accept = in_valid & in_ready & !rst;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (accept && d == SEL_W'(k)),
      .din  (in_data),
      .dout (out_data[k*W +: W]),
      .valid(out_valid[k]),
      .ready(out_ready[k])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= '0;
    else xfer_cnt <= xfer_cnt + CNT_W'(accept);
  end
endmodule

// File: doc/demux1to4_reg.md
Name: demux1to4_reg

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the team's 4-to-1 mux family.
- Accepts one data word per cycle on a valid/ready input and routes it to one of four output channels chosen by sel.
- Each output channel has its own one-entry holding register and valid/ready handshake.
- Sits where a shared bus fans out to four independent consumers.

Parameters:
- W, 8, data width of input word and of each output channel.
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  input word.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block can accept a word this cycle.
- sel  input  2  destination channel, sampled with the input word.
- out_data  output  4*W  channel k occupies bits [k*W +: W].
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: consumer k takes the word this cycle.
- xfer_cnt  output  CNT_W  count of accepted input words.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out_valid = 4'b0000.
  - out_data = 0.
  - xfer_cnt = 0.
  - in_ready is combinational; while rst is high it reads as the not-full value of the reset state, but no word is accepted on a cycle where rst is high.
- Destination d:
  - d = sel in the default build.
  - d = rr_ptr when DEMUX_RR_EN is defined.
- Ready rule:
  - in_ready = !out_valid[d] | out_ready[d].
  - This is combinational from sel/out_ready; there is no combinational path from in_valid.
- Accept rule:
  - accept = in_valid & in_ready & !rst.
  - On accept at edge t, channel d loads in_data and out_valid[d] = 1 from cycle t+1.
  - Latency is 1 cycle.
- Drain rule:
  - Channel k with out_valid[k] & out_ready[k] and no accept to k clears out_valid[k] on the next edge.
  - out_data[k] holds its last value; it is not cleared.
- Simultaneous drain and load on the same channel: the new word replaces the old one and out_valid stays 1. This gives full throughput of 1 word/cycle per channel.
- Stall and channel independence:
  - While channel d is full and not draining, in_ready = 0 and in_data/sel must be held by the source (standard valid/ready).
  - Other channels continue draining independently.
- Stability: out_data[k] and out_valid[k] never change while out_valid[k] = 1 and out_ready[k] = 0.
- xfer_cnt:
  - Increments by 1 per accept.
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset during operation: all buffered words are discarded and the counter is cleared on the edge where rst = 1, regardless of any handshake in that cycle.
- Sub-state per channel is an FSM:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load, with or without drain.

Optional Feature:
- Macro: DEMUX_RR_EN.
- Defined:
  - sel is ignored.
  - An internal 2-bit rr_ptr (reset 0) selects d and advances by 1 on each accept, wrapping 3 -> 0.
  - The pointer does not advance on stall cycles.
- Undefined: no rr_ptr exists and d = sel.
- Port list is identical in both builds.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH = 4.
  - SEL_W = 2.
  - Channel-state typedef {CH_EMPTY, CH_FULL}.
- Sub-module demux_slot:
  - One holding register: clk, rst, load, din, dout, valid, ready.
  - Instantiated 4 times by the top.
  - The top holds the decode, in_ready mux, counter and rr_ptr.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic with channel 2 full -> out_valid = 0000, xfer_cnt = 0 next cycle, no accept during rst.
- Routing: out_ready = 1111, send 0xA0..0xA3 with sel = 0,1,2,3 on consecutive cycles -> each out_valid[k] pulses for 1 cycle carrying 0xA0+k one cycle after its input; xfer_cnt = 4.
- Backpressure: out_ready[1] = 0, send 0x11 then 0x22 both sel = 1 -> 0x11 held on ch1, in_ready = 0 while sel = 1; switching sel = 3 with 0x33 is accepted. Releasing out_ready[1] then accepts 0x22 in the drain cycle (simultaneous drain/load), and out_valid[1] stays 1.
- Stability: ch0 full with 0x5A and out_ready[0] = 0 for 10 cycles -> out_data ch0 = 0x5A and out_valid[0] = 1 throughout.
- Counter wrap: CNT_W = 4, 17 accepts -> xfer_cnt reads 15 then 0 then 1.
- With DEMUX_RR_EN: sel held at 2, 6 accepts of 0x01..0x06 -> words land on ch 0,1,2,3,0,1. A stall cycle on ch2 does not advance rr_ptr.
